// File: rtl/reaction_avg.sv
// reaction_avg: running mean of the last 2**DEPTH_LOG2 reaction times.
// Each accepted BCD sample is converted to binary, stored in a circular
// buffer, the running sum is divided by the sample count with a restoring
// divider, and the quotient is converted back to BCD by double-dabble.
// Optional build macro: REACTION_AVG_ROUND_EN (round-half-up mean instead of
// a truncated one; latency is identical).
module reaction_avg #(
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [3:0]          d3,
    input  logic [3:0]          d2,
    input  logic [3:0]          d1,
    input  logic [3:0]          d0,
    input  logic                clear,
    output logic [3:0]          avg3,
    output logic [3:0]          avg2,
    output logic [3:0]          avg1,
    output logic [3:0]          avg0,
    output logic [DEPTH_LOG2:0] count,
    output logic                busy,
    output logic                avg_valid,
    output logic                err
);

    localparam int unsigned W     = 14 + DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DIV,
        S_CONV,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [13:0]           bin_q, bin_d;
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [W-1:0]          sum_q, sum_d;
    logic [W-1:0]          quot_q, quot_d;
    logic [CW-1:0]         rem_q, rem_d;
    logic [4:0]            step_q, step_d;
    logic [15:0]           bcd_q, bcd_d;
    logic [15:0]           avg_q, avg_d;
    logic                  err_q, err_d;

    logic [13:0]           mem_q [DEPTH];

    logic                  digits_ok;
    logic [13:0]           bin_in;
    logic                  full;
    logic [13:0]           evicted;
    logic [CW-1:0]         count_inc;
    logic [W-1:0]          sum_next;
    logic [W-1:0]          dividend;
    logic [CW:0]           shifted;
    logic [CW:0]           trial;
    logic [15:0]           bcd_next;

    function automatic logic [15:0] dd_adjust(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int unsigned i = 0; i < 4; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Input decode, buffer arithmetic, divider step and BCD shift step.
    always_comb begin
        digits_ok = (d3 <= 4'd9) && (d2 <= 4'd9) && (d1 <= 4'd9) && (d0 <= 4'd9);
        bin_in    = ((14'(d3) * 14'd10 + 14'(d2)) * 14'd10 + 14'(d1)) * 14'd10 + 14'(d0);
        full      = (count_q == CW'(DEPTH));
        evicted   = full ? mem_q[wptr_q] : '0;
        count_inc = full ? count_q : count_q + CW'(1);
        sum_next  = sum_q + W'(bin_q) - W'(evicted);
`ifdef REACTION_AVG_ROUND_EN
        dividend  = sum_next + W'(count_inc >> 1);
`else
        dividend  = sum_next;
`endif
        shifted   = {rem_q, quot_q[W-1]};
        trial     = shifted - {1'b0, count_q};
        bcd_next  = (dd_adjust(bcd_q) << 1) | 16'(quot_q[13]);
    end

    // Next-state logic of the sequencing FSM; clear always returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (sample_valid && digits_ok) state_d = S_LOAD;
                S_LOAD: state_d = S_DIV;
                S_DIV:  if (step_q == 5'(W - 1)) state_d = S_CONV;
                S_CONV: if (step_q == 5'd13) state_d = S_DONE;
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath next-state values per FSM state, with clear overriding all.
    always_comb begin
        bin_d   = bin_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        sum_d   = sum_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        step_d  = step_q;
        bcd_d   = bcd_q;
        avg_d   = avg_q;
        err_d   = err_q;

        if (sample_valid && ((state_q != S_IDLE) || !digits_ok)) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (sample_valid && digits_ok) bin_d = bin_in;
            end
            S_LOAD: begin
                wptr_d  = wptr_q + DEPTH_LOG2'(1);
                sum_d   = sum_next;
                count_d = count_inc;
                quot_d  = dividend;
                rem_d   = '0;
                step_d  = '0;
            end
            S_DIV: begin
                // Quotient bits shift into the dividend register as its
                // bits are consumed, so one register holds both.
                if (!trial[CW]) begin
                    rem_d  = trial[CW-1:0];
                    quot_d = {quot_q[W-2:0], 1'b1};
                end else begin
                    rem_d  = shifted[CW-1:0];
                    quot_d = {quot_q[W-2:0], 1'b0};
                end
                step_d = step_q + 5'd1;
                if (step_q == 5'(W - 1)) begin
                    step_d = '0;
                    bcd_d  = '0;
                end
            end
            S_CONV: begin
                bcd_d  = bcd_next;
                quot_d = {quot_q[W-2:0], 1'b0};
                step_d = step_q + 5'd1;
                // The final shift lands directly on the outputs so the new
                // digits are visible during the DONE cycle.
                if (step_q == 5'd13) avg_d = bcd_next;
            end
            default: ;
        endcase

        if (clear) begin
            wptr_d  = '0;
            count_d = '0;
            sum_d   = '0;
            avg_d   = '0;
            err_d   = 1'b0;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            sum_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            step_q  <= '0;
            bcd_q   <= '0;
            avg_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            step_q  <= step_d;
            bcd_q   <= bcd_d;
            avg_q   <= avg_d;
            err_q   <= err_d;
        end
    end

    // History buffer write; contents are never cleared, count marks validity.
    always_ff @(posedge clock) begin
        if (state_q == S_LOAD && !clear) begin
            mem_q[wptr_q] <= bin_q;
        end
    end

    assign avg3      = avg_q[15:12];
    assign avg2      = avg_q[11:8];
    assign avg1      = avg_q[7:4];
    assign avg0      = avg_q[3:0];
    assign count     = count_q;
    assign busy      = (state_q != S_IDLE);
    assign avg_valid = (state_q == S_DONE) && !clear;
    assign err       = err_q;

endmodule

// File: tb/tb_reaction_avg.sv
// Scoreboard bench for reaction_avg (DEPTH_LOG2 = 2). Expected averages come
// from an integer reference model of the history buffer.
module tb_reaction_avg;

    localparam int unsigned DL      = 2;
    localparam int unsigned DEPTH   = 1 << DL;
    localparam int unsigned LATENCY = 14 + DL + 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        sample_valid = 1'b0;
    logic [3:0]  d3 = '0, d2 = '0, d1 = '0, d0 = '0;
    logic        clear = 1'b0;
    logic [3:0]  avg3, avg2, avg1, avg0;
    logic [DL:0] count;
    logic        busy, avg_valid, err;

    reaction_avg #(.DEPTH_LOG2(DL)) dut (
        .clock(clock), .reset(reset), .sample_valid(sample_valid),
        .d3(d3), .d2(d2), .d1(d1), .d0(d0), .clear(clear),
        .avg3(avg3), .avg2(avg2), .avg1(avg1), .avg0(avg0),
        .count(count), .busy(busy), .avg_valid(avg_valid), .err(err)
    );

    always #10 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    typedef struct {
        int unsigned avg;
        int unsigned cnt;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned hist[DEPTH];
    int unsigned m_cnt = 0;
    int unsigned m_ptr = 0;

    function automatic int unsigned to_bcd(input int unsigned v);
        return ((v / 1000) % 10) << 12 | ((v / 100) % 10) << 8 | ((v / 10) % 10) << 4 | (v % 10);
    endfunction

    task automatic model_clear();
        m_cnt = 0;
        m_ptr = 0;
    endtask

    task automatic model_push(input int unsigned v, output exp_t e);
        int unsigned sum;
        hist[m_ptr] = v;
        m_ptr = (m_ptr + 1) % DEPTH;
        if (m_cnt < DEPTH) m_cnt++;
        sum = 0;
        for (int i = 0; i < int'(m_cnt); i++) sum += hist[i];
`ifdef REACTION_AVG_ROUND_EN
        sum += m_cnt / 2;
`endif
        e.avg = to_bcd(sum / m_cnt);
        e.cnt = m_cnt;
        e.cyc = cyc;
    endtask

    // Output side of the scoreboard.
    always @(negedge clock) begin
        if (reset && avg_valid) begin
            if (sb.size() == 0) begin
                check_val("spurious_avg_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("avg", {avg3, avg2, avg1, avg0}, e.avg);
                check_val("count_at_valid", count, e.cnt);
                check_val("latency", cyc - e.cyc, LATENCY);
            end
        end
    end

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        exp_t e;
        @(posedge clock); #1;
        d3 = a; d2 = b; d1 = c; d0 = d;
        sample_valid = 1'b1;
        model_push(int'(a) * 1000 + int'(b) * 100 + int'(c) * 10 + int'(d), e);
        sb.push_back(e);
        @(posedge clock); #1;
        sample_valid = 1'b0;
        check_val("busy_after_sample", busy, 1);
    endtask

    task automatic pulse_raw(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        @(posedge clock); #1;
        d3 = a; d2 = b; d1 = c; d0 = d;
        sample_valid = 1'b1;
        @(posedge clock); #1;
        sample_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            check_val("timeout_avg_valid", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic do_clear();
        @(posedge clock); #1;
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
        model_clear();
    endtask

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_val("rst_avg", {avg3, avg2, avg1, avg0}, 0);
        check_val("rst_count", count, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_avg_valid", avg_valid, 0);
        check_val("rst_err", err, 0);

        // First sample.
        send(0, 2, 3, 4);
        wait_done();
        check_val("err_after_first", err, 0);

        // Fill the window, then evict the oldest entry.
        do_clear();
        send(0, 1, 0, 0); wait_done();
        send(0, 2, 0, 0); wait_done();
        send(0, 3, 0, 0); wait_done();
        send(0, 4, 0, 0); wait_done();
        send(0, 5, 0, 0); wait_done();
        @(negedge clock);
        check_val("count_saturated", count, DEPTH);

        // Half-way mean: truncation or rounding depending on build.
        do_clear();
        send(0, 1, 0, 0); wait_done();
        send(0, 1, 0, 1); wait_done();

        // Invalid BCD digit.
        check_val("err_before_invalid", err, 0);
        pulse_raw(0, 1, 4'hA, 0);
        check_val("err_invalid", err, 1);
        check_val("count_invalid", count, 2);
        repeat (40) @(posedge clock);

        // Overrun five cycles after an accepted sample.
        do_clear();
        send(1, 2, 3, 4);
        repeat (3) @(posedge clock);
        pulse_raw(5, 5, 5, 5);
        check_val("err_overrun", err, 1);
        wait_done();
        do_clear();
        @(negedge clock);
        check_val("clr_count", count, 0);
        check_val("clr_avg", {avg3, avg2, avg1, avg0}, 0);
        check_val("clr_err", err, 0);

        // clear wins over a simultaneous sample, without an error.
        @(posedge clock); #1;
        clear = 1'b1; sample_valid = 1'b1; d3 = 7; d2 = 7; d1 = 7; d0 = 7;
        @(posedge clock); #1;
        clear = 1'b0; sample_valid = 1'b0;
        @(negedge clock);
        check_val("clr_sv_err", err, 0);
        check_val("clr_sv_count", count, 0);
        check_val("clr_sv_busy", busy, 0);

        // Asynchronous reset in the middle of a division.
        send(4, 3, 2, 1); wait_done();
        send(1, 1, 1, 1);
        pulse_raw(6, 6, 6, 6);
        @(posedge clock); #1;
        reset = 1'b0;
        sb.delete();
        model_clear();
        #1;
        check_val("arst_avg", {avg3, avg2, avg1, avg0}, 0);
        check_val("arst_count", count, 0);
        check_val("arst_busy", busy, 0);
        check_val("arst_avg_valid", avg_valid, 0);
        check_val("arst_err", err, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        send(9, 5, 9, 9);
        wait_done();
        check_val("final_count", count, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reaction_avg.md
# reaction_avg

Running-average stage downstream of the reaction timer. It captures each final reaction time (four BCD digits, units of 0.01 s) when the timer signals a stop, and keeps the last 2^DEPTH_LOG2 results in a circular buffer. It computes their mean with an iterative divider, converts the mean back to BCD, and presents it as four digits for the 7-segment multiplexer when the user selects the average display.

## Interface

Parameters:
- DEPTH_LOG2, default 2, log2 of history depth (4 samples); legal range 1–4.

Ports:
- clock  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-low reset.
- sample_valid  in  1  one-cycle pulse: d3..d0 hold a final reaction time.
- d3, d2, d1, d0  in  4 each  BCD digits of the sample, d3 most significant; value = d3·1000 + d2·100 + d1·10 + d0.
- clear  in  1  synchronous clear of history and flags.
- avg3, avg2, avg1, avg0  out  4 each  BCD digits of the current average.
- count  out  DEPTH_LOG2+1  number of stored samples, saturating at 2^DEPTH_LOG2.
- busy  out  1  high while a sample is being processed.
- avg_valid  out  1  one-cycle pulse when avg3..avg0 update.
- err  out  1  sticky error flag: invalid BCD digit or overrun.

## Operation

States: IDLE, LOAD, DIV, CONV, DONE.

- **IDLE, sample_valid=1, all digits ≤ 9:**
  - Latch the binary value, bin = ((d3·10+d2)·10+d1)·10+d0, 14 bits.
  - Go to LOAD.
- **IDLE, any digit > 9:** drop the sample, set err, stay in IDLE.
- **LOAD (1 cycle):**
  - Write bin at the write pointer and advance the pointer modulo 2^DEPTH_LOG2.
  - sum ← sum + bin − evicted. evicted is the overwritten entry when count is full, else 0.
  - sum is 14+DEPTH_LOG2 bits wide.
  - If count is not full, count increments.
- **DIV (W = 14+DEPTH_LOG2 cycles):**
  - Restoring shift-subtract division, one quotient bit per cycle.
  - Dividend is sum; divisor is the new count.
  - Quotient is 14 bits (≤ 9999); the remainder is discarded.
- **CONV (14 cycles):** double-dabble conversion of the quotient to four BCD digits, one shift per cycle.
- **DONE (1 cycle):**
  - Register the result onto avg3..avg0 and pulse avg_valid.
  - Return to IDLE.
- **Overrun:** sample_valid in any state other than IDLE drops the sample and sets err. Processing of the current sample continues.
- **clear:**
  - Valid in any state; it aborts processing.
  - Pointer, count, sum, avg digits and err all go to 0.
  - FSM goes to IDLE.
  - avg_valid is not pulsed.
  - clear wins over a simultaneous sample_valid, which is dropped without setting err.
- **Buffer RAM:** contents are not cleared; count alone determines which entries are valid.
- **Before the first sample:** avg digits read 0000.

## Timing

- **Reset values:** avg3..avg0 = 0, count = 0, busy = 0, avg_valid = 0, err = 0, FSM = IDLE.
- **Reset mid-operation:** outputs take their reset values immediately (asynchronous).
- **Latency:** avg_valid is asserted W+16 cycles after the sample_valid cycle; with DEPTH_LOG2=2 this is 32 cycles.
- **busy:** high from the cycle after sample_valid through the DONE cycle inclusive.
- **Back-to-back samples:** the next sample is accepted in the first IDLE cycle after DONE.
- **Update timing:** avg digits change only in the DONE cycle; count changes in the LOAD cycle.

## Configuration

- REACTION_AVG_ROUND_EN defined: the dividend is sum + (count >> 1), giving round-half-up to the nearest 0.01 s.
- REACTION_AVG_ROUND_EN undefined: the quotient is truncated.
- Latency is identical in both builds.

## Test plan

- Reset, then sample 0,2,3,4 → 32 cycles later avg_valid pulses, avg = 0,2,3,4, count = 1, err = 0.
- Samples 100, 200, 300, 400 → avg 0,2,5,0, count = 4; then sample 500 → 100 is evicted, avg 0,3,5,0, count stays 4.
- Samples 100 and 101 → avg 0,1,0,0 without REACTION_AVG_ROUND_EN; 0,1,0,1 with it defined.
- Sample with d1 = 4'hA → err = 1, count unchanged, no avg_valid.
- sample_valid re-pulsed 5 cycles after an accepted sample → second sample ignored, err = 1, and the first sample's average is still produced. Then pulse clear → count = 0, avg = 0000, err = 0.
- Drive reset low during DIV → all outputs 0 immediately. After release, sample 9,5,9,9 → avg 9,5,9,9.
